// File: rtl/voice_allocator_if.sv
// Event handshake between the MIDI event source and the voice allocator.
interface voice_allocator_if;
  logic        ev_valid;
  logic        ev_ready;
  logic [15:0] ev_data;

  modport master (output ev_valid, output ev_data, input ev_ready);
  modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/voice_allocator.sv
// Polyphony manager: assigns note-on events to voices, stealing the oldest
// active voice when none is free, and releases voices on note-off.
//
// state  | meaning
// IDLE   | ev_ready high, waiting for an event
// SCAN   | one voice examined per cycle, candidates accumulated
// COMMIT | chosen voice updated, pulses registered for the next cycle
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  voice_allocator_if.slave        ev,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [NUM_VOICES-1:0]   voice_start,
  output logic                    steal,
  output logic                    drop
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic              ev_on_q;
  logic [6:0]        ev_note_q;

  logic              match_vld_q, free_vld_q, old_vld_q;
  logic [IDX_W-1:0]  match_idx_q, free_idx_q, old_idx_q;
  logic [AGE_W-1:0]  old_age_q;

  logic [NUM_VOICES-1:0] active_q;
  logic [6:0]            note_q [NUM_VOICES];
  logic [AGE_W-1:0]      age_q  [NUM_VOICES];

  logic              tgt_vld, is_steal, is_drop;
  logic [IDX_W-1:0]  tgt_idx;

  logic unused_ev_bits;
  assign unused_ev_bits = ^ev.ev_data[7:0];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; ev_valid is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ev.ev_valid) state_d = SCAN;
      SCAN:    if (idx_q == LAST_IDX) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/commit decode: ready in IDLE, target selection by priority in COMMIT.
  always_comb begin
    ev.ev_ready = (state_q == IDLE);
    tgt_vld     = 1'b0;
    tgt_idx     = '0;
    is_steal    = 1'b0;
    is_drop     = 1'b0;
    if (state_q == COMMIT) begin
      if (ev_on_q) begin
        tgt_vld = 1'b1;
        if (match_vld_q)     tgt_idx = match_idx_q;
        else if (free_vld_q) tgt_idx = free_idx_q;
        else begin
          tgt_idx  = old_idx_q;
          is_steal = 1'b1;
        end
      end else if (match_vld_q) begin
        tgt_vld = 1'b1;
        tgt_idx = match_idx_q;
      end else begin
        is_drop = 1'b1;
      end
    end
  end

  // Event latch and candidate accumulation; strict '>' keeps lowest index on age ties.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q       <= '0;
      ev_on_q     <= 1'b0;
      ev_note_q   <= '0;
      match_vld_q <= 1'b0;
      free_vld_q  <= 1'b0;
      old_vld_q   <= 1'b0;
      match_idx_q <= '0;
      free_idx_q  <= '0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
    end else if (state_q == IDLE) begin
      if (ev.ev_valid) begin
        ev_on_q     <= ev.ev_data[15];
        ev_note_q   <= ev.ev_data[14:8];
        idx_q       <= '0;
        match_vld_q <= 1'b0;
        free_vld_q  <= 1'b0;
        old_vld_q   <= 1'b0;
      end
    end else if (state_q == SCAN) begin
      idx_q <= idx_q + 1'b1;
      if (active_q[idx_q] && note_q[idx_q] == ev_note_q && !match_vld_q) begin
        match_vld_q <= 1'b1;
        match_idx_q <= idx_q;
      end
      if (!active_q[idx_q] && !free_vld_q) begin
        free_vld_q <= 1'b1;
        free_idx_q <= idx_q;
      end
      if (active_q[idx_q] && (!old_vld_q || age_q[idx_q] > old_age_q)) begin
        old_vld_q <= 1'b1;
        old_idx_q <= idx_q;
        old_age_q <= age_q[idx_q];
      end
    end
  end

  // Per-voice state update at the commit edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= '0;
        age_q[v]  <= '0;
      end
    end else if (state_q == COMMIT) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (ev_on_q) begin
          if (tgt_vld && tgt_idx == IDX_W'(v)) begin
            active_q[v] <= 1'b1;
            note_q[v]   <= ev_note_q;
            age_q[v]    <= '0;
          end else if (active_q[v] && age_q[v] != AGE_MAX) begin
            age_q[v] <= age_q[v] + AGE_W'(1);
          end
        end else if (tgt_vld && tgt_idx == IDX_W'(v)) begin
          active_q[v] <= 1'b0;
        end
      end
    end
  end

  // One-cycle pulses following the commit edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      voice_start <= '0;
      steal       <= 1'b0;
      drop        <= 1'b0;
    end else begin
      voice_start <= '0;
      steal       <= is_steal;
      drop        <= is_drop;
      if (tgt_vld && ev_on_q) voice_start[tgt_idx] <= 1'b1;
    end
  end

  // Flatten note registers onto the output bus.
  always_comb begin
    voice_active = active_q;
    voice_note   = '0;
    for (int v = 0; v < NUM_VOICES; v++) voice_note[7*v +: 7] = note_q[v];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator with NUM_VOICES=4: directed vector table,
// reset-abort sequences and randomized events against a reference model.
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  voice_active;
  logic [27:0] voice_note;
  logic [3:0]  voice_start;
  logic        steal, drop;

  voice_allocator_if bus();

  voice_allocator #(.NUM_VOICES(4), .AGE_W(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ev           (bus),
    .voice_active (voice_active),
    .voice_note   (voice_note),
    .voice_start  (voice_start),
    .steal        (steal),
    .drop         (drop)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: plain per-voice arrays
  int m_act [4];
  int m_note[4];
  int m_age [4];

  typedef struct {
    logic        rst_before;
    logic [15:0] ev;
    logic [3:0]  act;
    logic [3:0]  st;
    logic        stl;
    logic        drp;
    logic [27:0] notes;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [27:0] pk(input int n0, input int n1, input int n2, input int n3);
    pk = {7'(n3), 7'(n2), 7'(n1), 7'(n0)};
  endfunction

  function automatic vec_t mk(input logic r, input logic [15:0] ev, input logic [3:0] act,
                              input logic [3:0] st, input logic stl, input logic drp,
                              input logic [27:0] notes);
    vec_t x;
    x.rst_before = r; x.ev = ev; x.act = act; x.st = st;
    x.stl = stl; x.drp = drp; x.notes = notes;
    return x;
  endfunction

  function automatic void model_clear();
    for (int v = 0; v < 4; v++) begin
      m_act[v] = 0; m_note[v] = 0; m_age[v] = 0;
    end
  endfunction

  function automatic void model_apply(input logic [15:0] ev, output logic [3:0] st,
                                      output logic stl, output logic drp);
    int tgt = -1;
    int n   = int'(ev[14:8]);
    int mx  = -1;
    st = 4'b0; stl = 1'b0; drp = 1'b0;
    for (int v = 0; v < 4; v++)
      if (tgt < 0 && m_act[v] != 0 && m_note[v] == n) tgt = v;
    if (ev[15]) begin
      for (int v = 0; v < 4; v++)
        if (tgt < 0 && m_act[v] == 0) tgt = v;
      if (tgt < 0) begin
        for (int v = 0; v < 4; v++)
          if (m_age[v] > mx) begin mx = m_age[v]; tgt = v; end
        stl = 1'b1;
      end
      for (int v = 0; v < 4; v++) begin
        if (v == tgt) begin
          m_act[v] = 1; m_note[v] = n; m_age[v] = 0;
        end else if (m_act[v] != 0) begin
          m_age[v] = (m_age[v] < 255) ? m_age[v] + 1 : 255;
        end
      end
      st[tgt] = 1'b1;
    end else begin
      if (tgt < 0) drp = 1'b1;
      else m_act[tgt] = 0;
    end
  endfunction

  function automatic logic [3:0] model_act();
    logic [3:0] a;
    for (int v = 0; v < 4; v++) a[v] = (m_act[v] != 0);
    return a;
  endfunction

  function automatic logic [27:0] model_notes();
    return pk(m_note[0], m_note[1], m_note[2], m_note[3]);
  endfunction

  // Drives one event; captures outputs in the cycle after the commit edge.
  task automatic send(input logic [15:0] ev, input int gap, input bit chk_clear,
                      output logic [3:0] a, output logic [3:0] st, output logic [27:0] nt,
                      output logic stl, output logic drp);
    int  n = 0;
    bit  scan_bad = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.ev_valid = 1'b1;
    bus.ev_data  = ev;
    while (!bus.ev_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("ready_timeout", 32'(bus.ev_ready), 32'd1);
    @(posedge clk); #1;
    bus.ev_data = 16'($urandom);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (bus.ev_ready || voice_start != 0 || steal || drop) scan_bad = 1;
    end
    bus.ev_valid = 1'b0;
    chk("busy_during_scan", 32'(scan_bad), 32'd0);
    @(posedge clk); #1;
    a = voice_active; st = voice_start; nt = voice_note; stl = steal; drp = drop;
    chk("ready_after_commit", 32'(bus.ev_ready), 32'd1);
    if (chk_clear) begin
      @(posedge clk); #1;
      chk("pulses_one_cycle", {26'd0, voice_start, steal, drop}, 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("reset_outputs_zero_act_note", {voice_active, voice_note}, 32'd0);
    chk("reset_pulses_zero", {26'd0, voice_start, steal, drop}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ready_after_reset", 32'(bus.ev_ready), 32'd1);
    model_clear();
  endtask

  // Starts an event and pulls reset after n_edges scan/commit-path edges.
  task automatic reset_abort(input logic [15:0] ev, input int n_edges);
    @(negedge clk);
    bus.ev_valid = 1'b1;
    bus.ev_data  = ev;
    @(posedge clk); #1;
    bus.ev_valid = 1'b0;
    repeat (n_edges) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_immediate_zero", {voice_active, voice_note}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (voice_active != 0 || voice_start != 0 || steal || drop)
        chk("abort_no_late_commit", {22'd0, voice_active, voice_start, steal, drop}, 32'd0);
    end
    chk("abort_state_clean", {voice_active, voice_note}, 32'd0);
    model_clear();
  endtask

  initial begin
    logic [3:0]  a, st, est;
    logic [27:0] nt;
    logic        stl, drp, estl, edrp;
    logic [15:0] ev;

    reset_n      = 1'b0;
    bus.ev_valid = 1'b0;
    bus.ev_data  = 16'h0;

    tbl[0]  = mk(0, 16'hBC00, 4'b0001, 4'b0001, 0, 0, pk('h3C, 0, 0, 0));
    tbl[1]  = mk(0, 16'hBE00, 4'b0011, 4'b0010, 0, 0, pk('h3C, 'h3E, 0, 0));
    tbl[2]  = mk(0, 16'hC000, 4'b0111, 4'b0100, 0, 0, pk('h3C, 'h3E, 'h40, 0));
    tbl[3]  = mk(0, 16'hC100, 4'b1111, 4'b1000, 0, 0, pk('h3C, 'h3E, 'h40, 'h41));
    tbl[4]  = mk(0, 16'hBE00, 4'b1111, 4'b0010, 0, 0, pk('h3C, 'h3E, 'h40, 'h41));
    tbl[5]  = mk(0, 16'h4000, 4'b1011, 4'b0000, 0, 0, pk('h3C, 'h3E, 'h40, 'h41));
    tbl[6]  = mk(0, 16'h5000, 4'b1011, 4'b0000, 0, 1, pk('h3C, 'h3E, 'h40, 'h41));
    tbl[7]  = mk(0, 16'hC300, 4'b1111, 4'b0100, 0, 0, pk('h3C, 'h3E, 'h43, 'h41));
    tbl[8]  = mk(0, 16'hC5A7, 4'b1111, 4'b0001, 1, 0, pk('h45, 'h3E, 'h43, 'h41));
    tbl[9]  = mk(0, 16'h4500, 4'b1110, 4'b0000, 0, 0, pk('h45, 'h3E, 'h43, 'h41));
    tbl[10] = mk(0, 16'h45FF, 4'b1110, 4'b0000, 0, 1, pk('h45, 'h3E, 'h43, 'h41));
    tbl[11] = mk(1, 16'hBC00, 4'b0001, 4'b0001, 0, 0, pk('h3C, 0, 0, 0));
    tbl[12] = mk(0, 16'hBE00, 4'b0011, 4'b0010, 0, 0, pk('h3C, 'h3E, 0, 0));
    tbl[13] = mk(0, 16'hC000, 4'b0111, 4'b0100, 0, 0, pk('h3C, 'h3E, 'h40, 0));
    tbl[14] = mk(0, 16'hC100, 4'b1111, 4'b1000, 0, 0, pk('h3C, 'h3E, 'h40, 'h41));
    tbl[15] = mk(0, 16'hC300, 4'b1111, 4'b0001, 1, 0, pk('h43, 'h3E, 'h40, 'h41));

    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("initial_ready", 32'(bus.ev_ready), 32'd1);
    chk("initial_outputs", {voice_active, voice_note}, 32'd0);

    // directed vectors
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].rst_before) do_reset();
      send(tbl[i].ev, 0, 1'b1, a, st, nt, stl, drp);
      chk($sformatf("vec%0d_active", i), 32'(a),   32'(tbl[i].act));
      chk($sformatf("vec%0d_notes", i),  32'(nt),  32'(tbl[i].notes));
      chk($sformatf("vec%0d_start", i),  32'(st),  32'(tbl[i].st));
      chk($sformatf("vec%0d_steal", i),  32'(stl), 32'(tbl[i].stl));
      chk($sformatf("vec%0d_drop", i),   32'(drp), 32'(tbl[i].drp));
    end

    // reset mid-SCAN, then the next note-on lands in voice 0
    reset_abort(16'hBC00, 2);
    send(16'hC500, 0, 1'b1, a, st, nt, stl, drp);
    chk("post_abort_active", 32'(a),   32'h1);
    chk("post_abort_start",  32'(st),  32'h1);
    chk("post_abort_steal",  32'(stl), 32'h0);
    chk("post_abort_note",   32'(nt),  32'(pk('h45, 0, 0, 0)));

    // reset while the commit is pending
    reset_abort(16'hBF00, 4);
    send(16'hBF00, 0, 1'b1, a, st, nt, stl, drp);
    chk("post_commit_abort_note",  32'(nt), 32'(pk('h3F, 0, 0, 0)));
    chk("post_commit_abort_start", 32'(st), 32'h1);

    // randomized events against the model, including back-to-back (gap 0)
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ev = {($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
            7'(8'h3C + $urandom_range(0, 5)), 8'($urandom)};
      model_apply(ev, est, estl, edrp);
      send(ev, $urandom_range(0, 2), 1'b0, a, st, nt, stl, drp);
      chk($sformatf("rnd%0d_active", i), 32'(a),   32'(model_act()));
      chk($sformatf("rnd%0d_notes", i),  32'(nt),  32'(model_notes()));
      chk($sformatf("rnd%0d_start", i),  32'(st),  32'(est));
      chk($sformatf("rnd%0d_steal", i),  32'(stl), 32'(estl));
      chk($sformatf("rnd%0d_drop", i),   32'(drp), 32'(edrp));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphony manager between the MIDI event source and the bank of phase-accumulator voices. Accepts note-on/note-off events in the synthesizer's 16-bit event word format and assigns each note-on to a free voice. When all voices are busy it steals the oldest one. It drives each voice's note number, gate and a start pulse that resets that voice's phase accumulator.

## Interface
Parameters:
- NUM_VOICES, 4: number of voice slots; power of two, 2..16
- AGE_W, 8: width of per-voice saturating age counter

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ev_valid  in  1  event word present
- ev_ready  out  1  allocator can accept an event; high only in IDLE
- ev_data  in  16  bit15 = 1 note-on / 0 note-off; bits14:8 = MIDI note; bits7:0 ignored
- voice_active  out  NUM_VOICES  per-voice gate
- voice_note  out  7*NUM_VOICES  voice v note at bits [7v+6:7v]
- voice_start  out  NUM_VOICES  one-cycle pulse: reset phase of voice v
- steal  out  1  one-cycle pulse: current note-on evicted an active voice
- drop  out  1  one-cycle pulse: note-off matched no active voice

## Operation
- Per-voice registers: active, note[6:0], age[AGE_W-1:0].
- FSM states: IDLE, SCAN, COMMIT.
  - IDLE: ev_ready=1. On ev_valid&&ev_ready, latch ev_data, clear candidates, idx<=0, go to SCAN.
  - SCAN: examine voice idx, one voice per cycle, idx increments.
    - After examining idx=NUM_VOICES-1, go to COMMIT.
    - ev_valid is ignored; the source must hold the event until ready.
  - COMMIT: apply the result, go to IDLE.
- Note-on target priority, where ties are broken by lowest index:
  1. Active voice with the same note (retrigger).
  2. Lowest-index inactive voice.
  3. Active voice with the maximum age (steal).
- Note-on commit:
  - Target: active<=1, note<=latched note, age<=0, voice_start[target]=1.
  - Every other active voice: age<=age+1, saturating at 2^AGE_W-1.
  - steal=1 only in case 3.
- Note-off commit:
  - Lowest-index active voice with a matching note: active<=0. Note and age are retained.
  - No match: drop=1 and nothing else changes.
- Inactive voices never age.
- voice_start, steal and drop are zero in all states except the cycle following the COMMIT edge.

## Timing
- Reset (async, immediate):
  - voice_active=0, voice_note=0, ages=0.
  - voice_start=0, steal=0, drop=0.
  - State IDLE, so ev_ready=1 once reset_n is high.
- Reset asserted mid-SCAN or at COMMIT aborts the event; no partial update survives.
- Handshake at edge E0:
  - SCAN occupies edges E1..E(NUM_VOICES).
  - COMMIT edge is E(NUM_VOICES+1).
- Outputs update and pulses are high in the cycle after E(NUM_VOICES+1). ev_ready returns high in that same cycle.
- Latency is NUM_VOICES+1 clocks. Maximum throughput is one event per NUM_VOICES+2 clocks.
- A new event presented in the first cycle ev_ready is high is accepted at that edge (back-to-back).
- voice_note and voice_active are registered, with no combinational path from ev_data.

## Test plan
All scenarios use NUM_VOICES=4, so commit is 5 edges after the handshake.
1. Reset while outputs are nonzero -> all outputs 0 immediately (no clock needed); ev_ready=1 after release.
2. Note-on 0x3F (ev_data=0xBF00) handshake at E0 -> after E5:
   - voice_active=4'b0001, voice_note[6:0]=0x3F, voice_start=4'b0001 for exactly one cycle.
   - ev_ready low during E1..E5.
3. Note-ons 0x3C, 0x3E, 0x40, 0x41, then 0x43:
   - First four fill voices 0..3.
   - Fifth sets steal=1, voice_start=4'b0001, voice 0 note=0x43, voice_active=4'b1111.
4. With voices holding 0x3C/0x3E/0x40/0x41, note-on 0x3E -> retrigger:
   - voice_start=4'b0010, steal=0, notes unchanged.
   - Voice 1 age=0; voices 0, 2, 3 age +1.
5. Note-off 0x40 -> voice_active=4'b1011, voice 2 note still 0x40. Then note-off 0x50 -> drop=1 for one cycle, no other change.
6. Note-on 0x3C, then reset_n pulsed low at E3 (mid-SCAN) -> all voices inactive. Next note-on 0x45 lands in voice 0 with no steal.
